// File: rtl/decode_stage.sv
// Decode stage: input holding register, 32x32 register file with write-through
// bypass, immediate generation, load-use stall detection and a registered decode bundle.
module decode_stage #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
    parameter int          XLEN      = 32
) (
    input  logic            CLOCK,
    input  logic            RESET,
    input  logic            IF_VALID,
    input  logic [31:0]     IF_IR,
    input  logic [XLEN-1:0] IF_PC,
    input  logic [XLEN-1:0] IF_PC_4,
    input  logic            FLUSH,
    input  logic            EX_MEM_READ,
    input  logic [4:0]      EX_RD,
    input  logic            WB_REG_WRITE,
    input  logic [4:0]      WB_RD,
    input  logic [XLEN-1:0] WB_DATA,
    output logic            PC_WRITE,
    output logic            DE_VALID,
    output logic [31:0]     DE_IR,
    output logic [XLEN-1:0] DE_PC,
    output logic [XLEN-1:0] DE_PC_4,
    output logic [4:0]      DE_RS1,
    output logic [4:0]      DE_RS2,
    output logic [4:0]      DE_RD,
    output logic [XLEN-1:0] DE_RS1_DATA,
    output logic [XLEN-1:0] DE_RS2_DATA,
    output logic [XLEN-1:0] DE_IMM
);

    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_REG   = 7'b0110011;

    logic            hr_valid;
    logic [31:0]     hr_ir;
    logic [XLEN-1:0] hr_pc;
    logic [XLEN-1:0] hr_pc4;

    logic [XLEN-1:0] regs [32];

    logic [6:0]      opcode;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            rs1_used;
    logic            rs2_used;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            stall;

    assign opcode = hr_ir[6:0];
    assign rs1    = hr_ir[19:15];
    assign rs2    = hr_ir[24:20];
    assign rd     = hr_ir[11:7];

    always_comb begin
        imm      = '0;
        rs1_used = 1'b1;
        rs2_used = 1'b0;
        case (opcode)
            OP_IMM, OP_LOAD, OP_JALR:
                imm = {{20{hr_ir[31]}}, hr_ir[31:20]};
            OP_STORE: begin
                imm      = {{20{hr_ir[31]}}, hr_ir[31:25], hr_ir[11:7]};
                rs2_used = 1'b1;
            end
            OP_BR: begin
                imm      = {{19{hr_ir[31]}}, hr_ir[31], hr_ir[7], hr_ir[30:25], hr_ir[11:8], 1'b0};
                rs2_used = 1'b1;
            end
            OP_LUI, OP_AUIPC: begin
                imm      = {hr_ir[31:12], 12'b0};
                rs1_used = 1'b0;
            end
            OP_JAL: begin
                imm      = {{11{hr_ir[31]}}, hr_ir[31], hr_ir[19:12], hr_ir[20], hr_ir[30:21], 1'b0};
                rs1_used = 1'b0;
            end
            OP_REG:
                rs2_used = 1'b1;
            default: imm = '0;
        endcase
    end

    // A writeback to the register being read this cycle is forwarded straight through.
    always_comb begin
        rs1_data = regs[rs1];
        rs2_data = regs[rs2];
        if (WB_REG_WRITE && WB_RD == rs1) rs1_data = WB_DATA;
        if (WB_REG_WRITE && WB_RD == rs2) rs2_data = WB_DATA;
        if (rs1 == 5'd0) rs1_data = '0;
        if (rs2 == 5'd0) rs2_data = '0;
    end

    assign stall = hr_valid && EX_MEM_READ && (EX_RD != 5'd0) &&
                   ((EX_RD == rs1 && rs1_used) || (EX_RD == rs2 && rs2_used));

    assign PC_WRITE = !stall || FLUSH;

    always_ff @(posedge CLOCK) begin
        if (!RESET) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (WB_REG_WRITE && WB_RD != 5'd0) begin
            regs[WB_RD] <= WB_DATA;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (!RESET) begin
            hr_valid <= 1'b0;
            hr_ir    <= NOP_INSTR;
            hr_pc    <= '0;
            hr_pc4   <= '0;
        end else if (FLUSH) begin
            hr_valid <= 1'b0;
        end else if (!stall) begin
            hr_valid <= IF_VALID;
            hr_ir    <= IF_IR;
            hr_pc    <= IF_PC;
            hr_pc4   <= IF_PC_4;
        end
    end

    // Flush, stall and an empty holding register all send a bubble downstream.
    always_ff @(posedge CLOCK) begin
        if (!RESET || FLUSH || stall || !hr_valid) begin
            DE_VALID    <= 1'b0;
            DE_IR       <= NOP_INSTR;
            DE_PC       <= '0;
            DE_PC_4     <= '0;
            DE_RS1      <= '0;
            DE_RS2      <= '0;
            DE_RD       <= '0;
            DE_RS1_DATA <= '0;
            DE_RS2_DATA <= '0;
            DE_IMM      <= '0;
        end else begin
            DE_VALID    <= 1'b1;
            DE_IR       <= hr_ir;
            DE_PC       <= hr_pc;
            DE_PC_4     <= hr_pc4;
            DE_RS1      <= rs1;
            DE_RS2      <= rs2;
            DE_RD       <= rd;
            DE_RS1_DATA <= rs1_data;
            DE_RS2_DATA <= rs2_data;
            DE_IMM      <= imm;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage.
module tb_decode_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        CLOCK = 1'b0;
    logic        RESET;
    logic        IF_VALID;
    logic [31:0] IF_IR;
    logic [31:0] IF_PC;
    logic [31:0] IF_PC_4;
    logic        FLUSH;
    logic        EX_MEM_READ;
    logic [4:0]  EX_RD;
    logic        WB_REG_WRITE;
    logic [4:0]  WB_RD;
    logic [31:0] WB_DATA;
    logic        PC_WRITE;
    logic        DE_VALID;
    logic [31:0] DE_IR;
    logic [31:0] DE_PC;
    logic [31:0] DE_PC_4;
    logic [4:0]  DE_RS1;
    logic [4:0]  DE_RS2;
    logic [4:0]  DE_RD;
    logic [31:0] DE_RS1_DATA;
    logic [31:0] DE_RS2_DATA;
    logic [31:0] DE_IMM;

    int checks = 0;
    int passed = 0;

    decode_stage dut (
        .CLOCK(CLOCK), .RESET(RESET), .IF_VALID(IF_VALID), .IF_IR(IF_IR),
        .IF_PC(IF_PC), .IF_PC_4(IF_PC_4), .FLUSH(FLUSH), .EX_MEM_READ(EX_MEM_READ),
        .EX_RD(EX_RD), .WB_REG_WRITE(WB_REG_WRITE), .WB_RD(WB_RD), .WB_DATA(WB_DATA),
        .PC_WRITE(PC_WRITE), .DE_VALID(DE_VALID), .DE_IR(DE_IR), .DE_PC(DE_PC),
        .DE_PC_4(DE_PC_4), .DE_RS1(DE_RS1), .DE_RS2(DE_RS2), .DE_RD(DE_RD),
        .DE_RS1_DATA(DE_RS1_DATA), .DE_RS2_DATA(DE_RS2_DATA), .DE_IMM(DE_IMM)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic fetch(input logic [31:0] ir, input logic [31:0] pc);
        IF_VALID = 1'b1;
        IF_IR    = ir;
        IF_PC    = pc;
        IF_PC_4  = pc + 32'd4;
    endtask

    task automatic idle_fetch();
        IF_VALID = 1'b0;
        IF_IR    = NOP;
        IF_PC    = '0;
        IF_PC_4  = '0;
    endtask

    task automatic test_reset();
        RESET = 1'b0; FLUSH = 1'b0; EX_MEM_READ = 1'b0; EX_RD = '0;
        WB_REG_WRITE = 1'b0; WB_RD = '0; WB_DATA = '0;
        idle_fetch();
        tick(); tick();
        checks++;
        if (DE_VALID !== 1'b0 || DE_IR !== NOP || DE_RD !== 5'd0 || DE_IMM !== 32'd0 || DE_PC !== 32'd0) begin
            $display("[TB] FAIL reset_bundle: valid=%b ir=%h rd=%0d imm=%h pc=%h, want 0/%h/0/0/0", DE_VALID, DE_IR, DE_RD, DE_IMM, DE_PC, NOP);
        end else passed++;
        checks++;
        if (PC_WRITE !== 1'b1) $display("[TB] FAIL reset_pc_write: got %b want 1", PC_WRITE);
        else passed++;
        RESET = 1'b1;
    endtask

    task automatic test_addi();
        fetch(32'h0050_0093, 32'h0);
        tick();
        idle_fetch();
        tick();
        checks++;
        if (DE_VALID !== 1'b1 || DE_RD !== 5'd1 || DE_IMM !== 32'd5 || DE_PC_4 !== 32'd4 || DE_RS1_DATA !== 32'd0)
            $display("[TB] FAIL addi: valid=%b rd=%0d imm=%h pc4=%h rs1d=%h, want 1/1/5/4/0", DE_VALID, DE_RD, DE_IMM, DE_PC_4, DE_RS1_DATA);
        else passed++;
        tick();
        checks++;
        if (DE_VALID !== 1'b0 || DE_IR !== NOP) $display("[TB] FAIL idle_bubble: valid=%b ir=%h want 0/%h", DE_VALID, DE_IR, NOP);
        else passed++;
    endtask

    task automatic test_bypass();
        fetch(32'h0031_8233, 32'h40);
        tick();
        idle_fetch();
        WB_REG_WRITE = 1'b1; WB_RD = 5'd3; WB_DATA = 32'hDEAD_BEEF;
        tick();
        WB_REG_WRITE = 1'b0; WB_DATA = '0;
        checks++;
        if (DE_RS1_DATA !== 32'hDEAD_BEEF || DE_RS2_DATA !== 32'hDEAD_BEEF || DE_RD !== 5'd4)
            $display("[TB] FAIL bypass: rs1d=%h rs2d=%h rd=%0d want deadbeef/deadbeef/4", DE_RS1_DATA, DE_RS2_DATA, DE_RD);
        else passed++;
        fetch(32'h0031_8233, 32'h44);
        tick();
        idle_fetch();
        tick();
        checks++;
        if (DE_RS1_DATA !== 32'hDEAD_BEEF || DE_PC !== 32'h44)
            $display("[TB] FAIL regfile_write: rs1d=%h pc=%h want deadbeef/44", DE_RS1_DATA, DE_PC);
        else passed++;
    endtask

    task automatic test_stall();
        fetch(32'h0002_8333, 32'h100);
        tick();
        fetch(32'h0050_0093, 32'h104);
        EX_MEM_READ = 1'b1; EX_RD = 5'd5;
        #1;
        checks++;
        if (PC_WRITE !== 1'b0) $display("[TB] FAIL stall_pc_write: got %b want 0", PC_WRITE);
        else passed++;
        tick();
        checks++;
        if (DE_VALID !== 1'b0 || DE_IR !== NOP || DE_RD !== 5'd0 || DE_PC !== 32'd0)
            $display("[TB] FAIL stall_bubble: valid=%b ir=%h rd=%0d pc=%h want 0/%h/0/0", DE_VALID, DE_IR, DE_RD, DE_PC, NOP);
        else passed++;
        EX_MEM_READ = 1'b0; EX_RD = '0;
        #1;
        checks++;
        if (PC_WRITE !== 1'b1) $display("[TB] FAIL stall_release: got %b want 1", PC_WRITE);
        else passed++;
        tick();
        checks++;
        if (DE_VALID !== 1'b1 || DE_IR !== 32'h0002_8333 || DE_RS1 !== 5'd5 || DE_RD !== 5'd6 || DE_PC !== 32'h100)
            $display("[TB] FAIL stall_resume: valid=%b ir=%h rs1=%0d rd=%0d pc=%h want 1/00028333/5/6/100", DE_VALID, DE_IR, DE_RS1, DE_RD, DE_PC);
        else passed++;
        idle_fetch();
        tick();
        checks++;
        if (DE_VALID !== 1'b1 || DE_PC !== 32'h104 || DE_RD !== 5'd1)
            $display("[TB] FAIL after_stall: valid=%b pc=%h rd=%0d want 1/104/1", DE_VALID, DE_PC, DE_RD);
        else passed++;
        tick();
    endtask

    task automatic test_flush();
        fetch(32'h0002_8333, 32'h200);
        tick();
        fetch(32'h0050_0093, 32'h204);
        EX_MEM_READ = 1'b1; EX_RD = 5'd5; FLUSH = 1'b1;
        #1;
        checks++;
        if (PC_WRITE !== 1'b1) $display("[TB] FAIL flush_pc_write: got %b want 1", PC_WRITE);
        else passed++;
        tick();
        FLUSH = 1'b0;
        idle_fetch();
        checks++;
        if (DE_VALID !== 1'b0 || DE_IR !== NOP) $display("[TB] FAIL flush_bubble: valid=%b ir=%h want 0/%h", DE_VALID, DE_IR, NOP);
        else passed++;
        #1;
        checks++;
        if (PC_WRITE !== 1'b1) $display("[TB] FAIL flush_hr_empty: pc_write=%b want 1", PC_WRITE);
        else passed++;
        tick();
        checks++;
        if (DE_VALID !== 1'b0) $display("[TB] FAIL flush_next: valid=%b want 0", DE_VALID);
        else passed++;
        EX_MEM_READ = 1'b0; EX_RD = '0;
    endtask

    task automatic test_imm();
        fetch(32'hFE00_0EE3, 32'h300);
        tick();
        fetch(32'hABCD_E0B7, 32'h304);
        tick();
        checks++;
        if (DE_IMM !== 32'hFFFF_FFFC) $display("[TB] FAIL imm_branch: got %h want fffffffc", DE_IMM);
        else passed++;
        fetch(32'h0050_A623, 32'h308);
        tick();
        checks++;
        if (DE_IMM !== 32'hABCD_E000) $display("[TB] FAIL imm_lui: got %h want abcde000", DE_IMM);
        else passed++;
        idle_fetch();
        tick();
        checks++;
        if (DE_IMM !== 32'd12 || DE_RS2 !== 5'd5) $display("[TB] FAIL imm_store: imm=%h rs2=%0d want 0000000c/5", DE_IMM, DE_RS2);
        else passed++;
    endtask

    task automatic test_x0();
        fetch(32'h0000_03B3, 32'h400);
        tick();
        idle_fetch();
        WB_REG_WRITE = 1'b1; WB_RD = 5'd0; WB_DATA = 32'h1234;
        tick();
        WB_REG_WRITE = 1'b0; WB_DATA = '0;
        checks++;
        if (DE_RS1_DATA !== 32'd0 || DE_RS2_DATA !== 32'd0) $display("[TB] FAIL x0_bypass: rs1d=%h rs2d=%h want 0/0", DE_RS1_DATA, DE_RS2_DATA);
        else passed++;
        fetch(32'h0000_03B3, 32'h404);
        tick();
        idle_fetch();
        tick();
        checks++;
        if (DE_RS1_DATA !== 32'd0 || DE_VALID !== 1'b1) $display("[TB] FAIL x0_read: rs1d=%h valid=%b want 0/1", DE_RS1_DATA, DE_VALID);
        else passed++;
    endtask

    task automatic test_reset_mid_stall();
        fetch(32'h0002_8333, 32'h500);
        tick();
        EX_MEM_READ = 1'b1; EX_RD = 5'd5;
        RESET = 1'b0;
        tick();
        checks++;
        if (PC_WRITE !== 1'b1 || DE_VALID !== 1'b0) $display("[TB] FAIL reset_stall: pc_write=%b valid=%b want 1/0", PC_WRITE, DE_VALID);
        else passed++;
        RESET = 1'b1; EX_MEM_READ = 1'b0; EX_RD = '0;
        fetch(32'h0031_8233, 32'h600);
        tick();
        idle_fetch();
        tick();
        checks++;
        if (DE_RS1_DATA !== 32'd0 || DE_VALID !== 1'b1) $display("[TB] FAIL reset_regfile: rs1d=%h valid=%b want 0/1", DE_RS1_DATA, DE_VALID);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_addi();
        test_bypass();
        test_stall();
        test_flush();
        test_imm();
        test_x0();
        test_reset_mid_stall();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
